// File: rtl/pwm_bank_dbuf.sv
`timescale 1ns/1ps
// Multi-channel PWM bank with per-channel enable/mode masks, a shared
// prescaler and double-buffered duty registers. Shadow duties are copied to
// the active set only on a period wrap, so a period is never cut short.
module pwm_bank_dbuf #(
  parameter int NUM_CH  = 8,
  parameter int CLK_DIV = 12,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              duty_pending
);

  localparam int unsigned NCH   = NUM_CH;
  localparam int          DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [7:0]        pwm_cnt;
  logic              tick;
  logic              boundary;

  logic [NUM_CH-1:0] out_en;
  logic [NUM_CH-1:0] pwm_mode;
  logic [7:0]        duty_shadow [NUM_CH];
  logic [7:0]        duty_act    [NUM_CH];

  logic              sel_en;
  logic              sel_mode;
  logic [NUM_CH-1:0] sel_duty;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] mismatch;

  // Register address decode; anything outside the map selects nothing.
  always_comb begin
    sel_en   = wr_en && (wr_addr == ADDR_W'(0));
    sel_mode = wr_en && (wr_addr == ADDR_W'(1));
    sel_duty = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sel_duty[i] = wr_en && (wr_addr == ADDR_W'(i + 2));
    end
  end

  // Tick and period-wrap strobes; sync_clr suppresses the wrap that cycle.
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    boundary = tick && (pwm_cnt == 8'hFF) && !sync_clr;
  end

  // Prescaler: counts 0..CLK_DIV-1, restarted by sync_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (sync_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // 8-bit period counter, advances on tick and wraps 255->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (sync_clr) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Enable and mode mask registers; bits above NUM_CH are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en   <= '0;
      pwm_mode <= '0;
    end else begin
      if (sel_en)   out_en   <= wr_data[NUM_CH-1:0];
      if (sel_mode) pwm_mode <= wr_data[NUM_CH-1:0];
    end
  end

  // Shadow/active duty pair. A write in the wrap cycle lands in the shadow
  // while the active copy takes the pre-write shadow value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_shadow[i] <= '0;
        duty_act[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (boundary)    duty_act[i]    <= duty_shadow[i];
        if (sel_duty[i]) duty_shadow[i] <= wr_data;
      end
    end
  end

  // Per-channel compare level and shadow/active difference.
  always_comb begin
    level    = '0;
    mismatch = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      level[i]    = (duty_act[i] == 8'hFF) || (pwm_cnt < duty_act[i]);
      mismatch[i] = (duty_shadow[i] != duty_act[i]);
    end
  end

  // Registered outputs: channel levels, wrap pulse and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      duty_pending <= 1'b0;
    end else begin
      pwm_out      <= out_en & ((pwm_mode & level) | ~pwm_mode);
      period_start <= boundary;
      duty_pending <= |mismatch;
    end
  end

endmodule

// File: tb/tb_pwm_bank_dbuf.sv
`timescale 1ns/1ps
// Directed bench for pwm_bank_dbuf with CLK_DIV=1 (one period = 256 clocks).
module tb_pwm_bank_dbuf;

  localparam int NUM_CH  = 8;
  localparam int CLK_DIV = 1;
  localparam int ADDR_W  = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              sync_clr = 1'b0;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;
  logic              duty_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_bank_dbuf #(
    .NUM_CH (NUM_CH),
    .CLK_DIV(CLK_DIV),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sync_clr    (sync_clr),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .duty_pending(duty_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle register write, driven at a falling edge.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Starts on the falling edge that shows period_start; observes the next
  // 256 falling edges. Sample k reflects pwm_cnt == k. Optionally issues a
  // write captured while pwm_cnt == wr_at (wr_at = 255 hits the wrap cycle).
  task automatic period_chk(input string tag, input int wr_at,
                            input logic [ADDR_W-1:0] a, input logic [7:0] d,
                            input int exp_hi, input logic exp_pend);
    int   hi;
    int   ps_cnt;
    logic pend_mid;
    logic ps_end;
    hi = 0; ps_cnt = 0; pend_mid = 1'b0; ps_end = 1'b0;
    for (int k = 0; k < 256; k++) begin
      wr_en   = (k == wr_at);
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      if (pwm_out[0])   hi++;
      if (period_start) ps_cnt++;
      if (k == 128)     pend_mid = duty_pending;
      if (k == 255)     ps_end = period_start;
    end
    wr_en = 1'b0;
    check({tag, "_hi"},    hi,       exp_hi);
    check({tag, "_pend"},  pend_mid, exp_pend);
    check({tag, "_pscnt"}, ps_cnt,   1);
    check({tag, "_psend"}, ps_end,   1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic found;

    // Reset state before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_pwm",  pwm_out,      8'h00);
    check("rst_ps",   period_start, 1'b0);
    check("rst_pend", duty_pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Channel 0 enabled in PWM mode, duty 0x40
    wr(7'h00, 8'h01);
    wr(7'h01, 8'h01);
    wr(7'h02, 8'h40);
    @(negedge clk);
    check("init_pend", duty_pending, 1'b1);
    check("init_pwm",  pwm_out,      8'h00);

    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    check("first_ps", found, 1'b1);

    // Steady 64/256, then double buffer: 0xC0 written at pwm_cnt=10
    period_chk("steady",  -1, 7'h02, 8'h00, 64,  1'b0);
    period_chk("dbuf_wr", 10, 7'h02, 8'hC0, 64,  1'b1);
    period_chk("dbuf_nx", -1, 7'h02, 8'h00, 192, 1'b0);

    // Collision: write 0x20 in the wrap cycle; 0xC0 transferred first
    period_chk("coll_wr", 255, 7'h02, 8'h20, 192, 1'b0);
    period_chk("coll_p1", -1,  7'h02, 8'h00, 192, 1'b1);
    period_chk("coll_p2", -1,  7'h02, 8'h00, 32,  1'b0);

    // Full on across periods, then duty 0 constant low
    period_chk("ff_wr",   0,  7'h02, 8'hFF, 32,  1'b1);
    period_chk("ff_p1",   -1, 7'h02, 8'h00, 256, 1'b0);
    period_chk("ff_p2",   -1, 7'h02, 8'h00, 256, 1'b0);
    period_chk("zero_wr", 0,  7'h02, 8'h00, 256, 1'b1);
    period_chk("zero_p1", -1, 7'h02, 8'h00, 0,   1'b0);

    // Mode 0 -> constant high, two cycles after the write edge
    wr(7'h01, 8'h00);
    check("mode_lat1", pwm_out[0], 1'b0);
    @(negedge clk);
    check("mode_lat2", pwm_out, 8'h01);

    wr(7'h00, 8'h81);
    @(negedge clk);
    check("en_ch7", pwm_out, 8'h81);

    // Unmapped addresses (0x7F, and 0x0A just past the last channel)
    wr(7'h7F, 8'hFF);
    wr(7'h0A, 8'h55);
    @(negedge clk);
    @(negedge clk);
    check("unmap_pwm",  pwm_out,      8'h81);
    check("unmap_pend", duty_pending, 1'b0);

    // Last channel duty register at 0x09
    wr(7'h09, 8'h40);
    @(negedge clk);
    check("ch7_pend", duty_pending, 1'b1);

    // sync_clr with a concurrent enable write; wrap 256*CLK_DIV+1 later
    sync_clr = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 7'h00;
    wr_data  = 8'h83;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (i == 1) begin
        sync_clr = 1'b0;
        wr_en    = 1'b0;
      end
      if (i == 2) check("sclr_wr", pwm_out, 8'h83);
      if (period_start) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    check("sclr_found", found, 1'b1);
    check("sclr_delay", n,     257);

    // Mid-operation asynchronous reset with outputs and pending high
    wr(7'h03, 8'h10);
    @(negedge clk);
    check("pre_rst_pend", duty_pending, 1'b1);
    check("pre_rst_pwm",  pwm_out,      8'h83);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm",  pwm_out,      8'h00);
    check("arst_ps",   period_start, 1'b0);
    check("arst_pend", duty_pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
